timer_bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3) between the TLC controller's 8-bit countdown Timer and the seven-segment driver's 4-bit digit inputs.
- Accepts one binary value per valid/ready handshake, produces DIGITS BCD nibbles plus a leading-zero blank mask, and holds the result until the next conversion completes.

---
 rtl/timer_bcd_converter.sv | 124 ++++++++++++
 tb/tb_timer_bcd_converter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with leading-zero blank mask.
// One value per valid/ready handshake; the result holds until the next conversion completes.
module timer_bcd_converter #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3,
   parameter int LZB_EN = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     blank_mask
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);
   localparam logic [DIGITS-1:0] RST_MASK = (LZB_EN != 0) ? ~ONE_HOT0 : '0;

   function automatic bit digits_fit(input int d, input int w);
      longint unsigned p10 = 1;
      for (int i = 0; i < d; i++) p10 = p10 * 10;
      return p10 > (64'd1 << w);
   endfunction

   localparam bit DIGITS_OK = digits_fit(DIGITS, BIN_W);

   generate
      if (!DIGITS_OK) begin : g_param_check
         $error("timer_bcd_converter: 10**DIGITS must exceed 2**BIN_W");
      end
   endgenerate

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BIN_W-1:0]    r_bin;
   logic [BCD_W-1:0]    r_scratch;
   logic [CNT_W-1:0]    r_cnt;
   logic [BCD_W-1:0]    r_bcd;
   logic [DIGITS-1:0]   r_mask;
   logic                r_out_valid;

   logic                w_accept;
   logic                w_last;
   logic [BCD_W-1:0]    w_adj;
   logic [BCD_W-1:0]    w_scratch_nxt;
   logic [DIGITS-1:0]   w_mask_nxt;
   logic                w_zero_above;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = SHIFT;
         SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Nibbles are adjusted independently (no inter-nibble carry); the shift drops the scratch MSB.
   always_comb begin
      w_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ? r_scratch[4*i +: 4] + 4'd3
                                                          : r_scratch[4*i +: 4];
      end
      w_scratch_nxt = (w_adj << 1) | BCD_W'(r_bin[BIN_W-1]);
   end

   always_comb begin
      w_mask_nxt   = '0;
      w_zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_above  = w_zero_above && (w_scratch_nxt[4*i +: 4] == 4'd0);
         w_mask_nxt[i] = w_zero_above && (LZB_EN != 0);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin       <= '0;
         r_scratch   <= '0;
         r_cnt       <= '0;
         r_bcd       <= '0;
         r_mask      <= RST_MASK;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_last;
         if (w_accept) begin
            r_bin     <= bin_in;
            r_scratch <= '0;
            r_cnt     <= CNT_W'(BIN_W);
         end else if (r_state == SHIFT) begin
            r_bin     <= r_bin << 1;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= r_cnt - CNT_W'(1);
            if (w_last) begin
               r_bcd  <= w_scratch_nxt;
               r_mask <= w_mask_nxt;
            end
         end
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = r_out_valid;
   assign bcd_out    = r_bcd;
   assign blank_mask = r_mask;

endmodule

// File: tb/tb_timer_bcd_converter.sv
// Scoreboard bench for timer_bcd_converter: a cycle-level reference model queues expected
// results at accept time; a negedge monitor compares whenever the DUT presents out_valid.
module tb_timer_bcd_converter;

   localparam int BIN_W  = 8;
   localparam int DIGITS = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic [BIN_W-1:0]    bin_in;
   logic                in_ready, out_valid;
   logic [4*DIGITS-1:0] bcd_out;
   logic [DIGITS-1:0]   blank_mask;
   logic                in_ready_nb, out_valid_nb;
   logic [4*DIGITS-1:0] bcd_out_nb;
   logic [DIGITS-1:0]   blank_mask_nb;

   int n_tests = 0;
   int n_fail  = 0;

   timer_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS), .LZB_EN(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
      .out_valid(out_valid), .bcd_out(bcd_out), .blank_mask(blank_mask)
   );

   timer_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS), .LZB_EN(0)) dut_nb (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nb), .bin_in(bin_in),
      .out_valid(out_valid_nb), .bcd_out(bcd_out_nb), .blank_mask(blank_mask_nb)
   );

   always #5 clk = ~clk;

   function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Digit i is a blankable leading zero exactly when the value is below 10**i.
   function automatic logic [DIGITS-1:0] blank_of(input int v);
      logic [DIGITS-1:0] m;
      int p;
      m = '0;
      p = 10;
      for (int i = 1; i < DIGITS; i++) begin
         m[i] = (v < p);
         p = p * 10;
      end
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: busy for BIN_W edges after an accept, result pulses the cycle after.
   int                  exp_q[$];
   int                  m_busy   = 0;
   bit                  m_pulse  = 1'b0;
   logic [4*DIGITS-1:0] held_bcd = '0;
   logic [DIGITS-1:0]   held_mask = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy    = 0;
         m_pulse   = 1'b0;
         exp_q.delete();
         held_bcd  = '0;
         held_mask = blank_of(0);
      end else begin
         m_pulse = (m_busy == 1);
         if (m_busy == 0) begin
            if (in_valid) begin
               exp_q.push_back(int'(bin_in));
               m_busy = BIN_W;
            end
         end else begin
            m_busy = m_busy - 1;
         end
      end
   end

   always @(negedge clk) begin
      check("in_ready", 32'(in_ready), 32'(m_busy == 0));
      check("out_valid", 32'(out_valid), 32'(m_pulse));
      check("out_valid_nb", 32'(out_valid_nb), 32'(m_pulse));
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: out_valid with bcd %0h but nothing expected", bcd_out);
         end else begin
            int v;
            v = exp_q.pop_front();
            held_bcd  = to_bcd(v);
            held_mask = blank_of(v);
         end
      end
      check("bcd_out", 32'(bcd_out), 32'(held_bcd));
      check("blank_mask", 32'(blank_mask), 32'(held_mask));
      check("bcd_out_nb", 32'(bcd_out_nb), 32'(held_bcd));
      check("blank_mask_nb", 32'(blank_mask_nb), 32'(0));
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int v);
      in_valid = 1'b1;
      bin_in   = BIN_W'(v);
      cyc(1);
      in_valid = 1'b0;
      bin_in   = BIN_W'($urandom);
      cyc(12);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      bin_in   = '0;
      cyc(2);
      reset = 1'b0;
      cyc(20);

      send(255);
      send(42);
      send(9);
      send(100);
      send(0);
      send(5);

      // All inputs back to back with in_valid held high; bin_in scrambled between accepts.
      in_valid = 1'b1;
      for (int v = 0; v < (1 << BIN_W); v++) begin
         bin_in = BIN_W'(v);
         cyc(1);
         repeat (8) begin
            bin_in = BIN_W'($urandom);
            cyc(1);
         end
      end
      in_valid = 1'b0;
      cyc(12);

      // Requests during SHIFT must be ignored.
      in_valid = 1'b1;
      bin_in   = BIN_W'(37);
      cyc(1);
      in_valid = 1'b0;
      cyc(2);
      in_valid = 1'b1;
      bin_in   = BIN_W'(99);
      cyc(1);
      in_valid = 1'b0;
      cyc(1);
      in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
      cyc(12);

      // Reset part way through a conversion aborts it.
      in_valid = 1'b1;
      bin_in   = BIN_W'(200);
      cyc(1);
      in_valid = 1'b0;
      cyc(3);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(12);
      send(75);

      // Random traffic with occasional resets.
      for (int c = 0; c < 600; c++) begin
         in_valid = ($urandom_range(0, 3) == 0);
         bin_in   = BIN_W'($urandom);
         reset    = ($urandom_range(0, 149) == 0);
         cyc(1);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      cyc(12);

      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
